// File: rtl/lotr_pkg.sv
// rtl/lotr_pkg.sv - shared LOTR ring types and requestor-ID field constants
package lotr_pkg;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    RD_REQ = 3'd1,
    WR_REQ = 3'd2,
    RD_RSP = 3'd3,
    WR_RSP = 3'd4
  } t_opcode;

  localparam int CORE_ID_MSB = 9;
  localparam int CORE_ID_LSB = 2;
  localparam int THREAD_ID_W = 2;
  localparam int REQUESTOR_W = CORE_ID_MSB + 1;

  typedef struct packed {
    logic                   valid;
    logic [REQUESTOR_W-1:0] requestor;
    t_opcode                opcode;
    logic [31:0]            address;
    logic [31:0]            data;
  } t_ring_req;

  function automatic logic is_rsp(input t_opcode op);
    return (op == RD_RSP) || (op == WR_RSP);
  endfunction

endpackage

// File: rtl/lotr_rr_picker.sv
// rtl/lotr_rr_picker.sv - combinational round-robin picker: first eligible index at or after ptr
module lotr_rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any
);

  always_comb begin
    winner = ptr;
    any    = 1'b0;
    // Walk the search order backwards so the closest candidate to ptr is assigned last.
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[W'((int'(ptr) + i) % N)]) begin
        winner = W'((int'(ptr) + i) % N);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lotr_ring_inj_arb.sv
// rtl/lotr_ring_inj_arb.sv - ring-stop injection arbiter; LOTR_INJ_STARVE_CNT_EN enables the starvation counter
module lotr_ring_inj_arb
  import lotr_pkg::*;
#(
  parameter int NUM_THREADS  = 4,
  parameter int RSP_TIMEOUT  = 1023,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                                QClk,
  input  logic                                RstQnnnH,
  input  logic [7:0]                          CoreID,
  input  logic [NUM_THREADS-1:0]              ThreadReqValid,
  input  t_opcode [NUM_THREADS-1:0]           ThreadReqOpcode,
  input  logic [NUM_THREADS-1:0][31:0]        ThreadReqAddress,
  input  logic [NUM_THREADS-1:0][31:0]        ThreadReqData,
  output logic [NUM_THREADS-1:0]              ThreadReqGrant,
  output logic [NUM_THREADS-1:0]              ThreadOutstanding,
  output logic [NUM_THREADS-1:0]              ThreadTimeout,
  input  logic                                RingReqInValid,
  input  logic [REQUESTOR_W-1:0]              RingReqInRequestor,
  input  t_opcode                             RingReqInOpcode,
  input  logic [31:0]                         RingReqInAddress,
  input  logic [31:0]                         RingReqInData,
  input  logic                                RingReqInTaken,
  input  logic                                RingRspInValid,
  input  logic [REQUESTOR_W-1:0]              RingRspInRequestor,
  input  t_opcode                             RingRspInOpcode,
  output logic                                RingReqOutValid,
  output logic [REQUESTOR_W-1:0]              RingReqOutRequestor,
  output t_opcode                             RingReqOutOpcode,
  output logic [31:0]                         RingReqOutAddress,
  output logic [31:0]                         RingReqOutData,
  output logic                                StarveFlag
);

  localparam int TO_W = $clog2(RSP_TIMEOUT + 1);

  if (NUM_THREADS != (1 << THREAD_ID_W) || RSP_TIMEOUT < 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("lotr_ring_inj_arb: unsupported parameter set");
  end

  t_ring_req ring_in, ring_nxt, ring_out;
  logic pass_through, any_elig, rsp_match;
  logic [NUM_THREADS-1:0] eligible, grant, rsp_clr, to_hit, outstanding, timeout;
  logic [THREAD_ID_W-1:0] rr_ptr, winner;
  logic [TO_W-1:0] to_cnt [NUM_THREADS];

  always_comb begin
    ring_in.valid     = RingReqInValid;
    ring_in.requestor = RingReqInRequestor;
    ring_in.opcode    = RingReqInOpcode;
    ring_in.address   = RingReqInAddress;
    ring_in.data      = RingReqInData;
  end

  assign pass_through = RingReqInValid && !RingReqInTaken;
  assign eligible     = ThreadReqValid & ~outstanding;

  lotr_rr_picker #(.N(NUM_THREADS), .W(THREAD_ID_W)) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .winner   (winner),
    .any      (any_elig)
  );

  always_comb begin
    grant = '0;
    if (!RstQnnnH && !pass_through && any_elig) grant[winner] = 1'b1;
  end

  // Responses for threads with nothing in flight are masked off here.
  assign rsp_match = RingRspInValid && (RingRspInRequestor[CORE_ID_MSB:CORE_ID_LSB] == CoreID)
                     && is_rsp(RingRspInOpcode);
  assign rsp_clr   = rsp_match ? ((NUM_THREADS'(1) << RingRspInRequestor[THREAD_ID_W-1:0]) & outstanding)
                               : '0;

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++)
      to_hit[t] = outstanding[t] && !rsp_clr[t] && (to_cnt[t] == TO_W'(RSP_TIMEOUT - 1));
  end

  always_comb begin
    ring_nxt = '0;
    if (pass_through) begin
      ring_nxt = ring_in;
    end else if (any_elig) begin
      ring_nxt.valid     = 1'b1;
      ring_nxt.requestor = {CoreID, winner};
      ring_nxt.opcode    = ThreadReqOpcode[winner];
      ring_nxt.address   = ThreadReqAddress[winner];
      ring_nxt.data      = ThreadReqData[winner];
    end
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      ring_out    <= '0;
      rr_ptr      <= '0;
      outstanding <= '0;
      timeout     <= '0;
      for (int t = 0; t < NUM_THREADS; t++) to_cnt[t] <= '0;
    end else begin
      ring_out <= ring_nxt;
      timeout  <= to_hit;
      if (|grant) rr_ptr <= winner + 2'd1;
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (grant[t]) begin
          outstanding[t] <= 1'b1;
          to_cnt[t]      <= '0;
        end else if (rsp_clr[t] || to_hit[t]) begin
          outstanding[t] <= 1'b0;
          to_cnt[t]      <= '0;
        end else if (outstanding[t]) begin
          to_cnt[t] <= to_cnt[t] + 1'b1;
        end
      end
    end
  end

`ifdef LOTR_INJ_STARVE_CNT_EN
  localparam int SV_W = $clog2(STARVE_LIMIT + 1);
  logic [SV_W-1:0] starve_cnt;

  always_ff @(posedge QClk) begin
    if (RstQnnnH)
      starve_cnt <= '0;
    else if (|grant)
      starve_cnt <= '0;
    else if (pass_through && (|eligible) && (starve_cnt != SV_W'(STARVE_LIMIT)))
      starve_cnt <= starve_cnt + 1'b1;
  end

  assign StarveFlag = (starve_cnt >= SV_W'(STARVE_LIMIT));
`else
  assign StarveFlag = 1'b0;
`endif

  assign ThreadReqGrant      = grant;
  assign ThreadOutstanding   = outstanding;
  assign ThreadTimeout       = timeout;
  assign RingReqOutValid     = ring_out.valid;
  assign RingReqOutRequestor = ring_out.requestor;
  assign RingReqOutOpcode    = ring_out.opcode;
  assign RingReqOutAddress   = ring_out.address;
  assign RingReqOutData      = ring_out.data;

endmodule

// File: tb/tb_lotr_ring_inj_arb.sv
// tb/tb_lotr_ring_inj_arb.sv - scoreboard bench for lotr_ring_inj_arb (RSP_TIMEOUT = 8)
module tb_lotr_ring_inj_arb;
  import lotr_pkg::*;

`ifdef LOTR_INJ_STARVE_CNT_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic QClk = 1'b0;
  logic RstQnnnH;
  logic [7:0] CoreID;
  logic [3:0] ThreadReqValid;
  t_opcode [3:0] ThreadReqOpcode;
  logic [3:0][31:0] ThreadReqAddress;
  logic [3:0][31:0] ThreadReqData;
  logic [3:0] ThreadReqGrant, ThreadOutstanding, ThreadTimeout;
  logic RingReqInValid, RingReqInTaken, RingRspInValid;
  logic [9:0] RingReqInRequestor, RingRspInRequestor;
  t_opcode RingReqInOpcode, RingRspInOpcode;
  logic [31:0] RingReqInAddress, RingReqInData;
  logic RingReqOutValid;
  logic [9:0] RingReqOutRequestor;
  t_opcode RingReqOutOpcode;
  logic [31:0] RingReqOutAddress, RingReqOutData;
  logic StarveFlag;

  int n_chk = 0;
  int n_fail = 0;
  t_ring_req sb[$];
  t_ring_req dut_slot;

  always #5 QClk = ~QClk;

  lotr_ring_inj_arb #(.NUM_THREADS(4), .RSP_TIMEOUT(8), .STARVE_LIMIT(15)) dut (
    .QClk(QClk), .RstQnnnH(RstQnnnH), .CoreID(CoreID),
    .ThreadReqValid(ThreadReqValid), .ThreadReqOpcode(ThreadReqOpcode),
    .ThreadReqAddress(ThreadReqAddress), .ThreadReqData(ThreadReqData),
    .ThreadReqGrant(ThreadReqGrant), .ThreadOutstanding(ThreadOutstanding),
    .ThreadTimeout(ThreadTimeout),
    .RingReqInValid(RingReqInValid), .RingReqInRequestor(RingReqInRequestor),
    .RingReqInOpcode(RingReqInOpcode), .RingReqInAddress(RingReqInAddress),
    .RingReqInData(RingReqInData), .RingReqInTaken(RingReqInTaken),
    .RingRspInValid(RingRspInValid), .RingRspInRequestor(RingRspInRequestor),
    .RingRspInOpcode(RingRspInOpcode),
    .RingReqOutValid(RingReqOutValid), .RingReqOutRequestor(RingReqOutRequestor),
    .RingReqOutOpcode(RingReqOutOpcode), .RingReqOutAddress(RingReqOutAddress),
    .RingReqOutData(RingReqOutData), .StarveFlag(StarveFlag)
  );

  always_comb begin
    dut_slot.valid     = RingReqOutValid;
    dut_slot.requestor = RingReqOutRequestor;
    dut_slot.opcode    = RingReqOutOpcode;
    dut_slot.address   = RingReqOutAddress;
    dut_slot.data      = RingReqOutData;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic t_ring_req thr_slot(input int t);
    t_ring_req s;
    s.valid     = 1'b1;
    s.requestor = {8'd2, 2'(t)};
    s.opcode    = (t % 2 == 1) ? WR_REQ : RD_REQ;
    s.address   = 32'h1000_0000 + 32'(t);
    s.data      = 32'hD000_0000 + 32'(t);
    return s;
  endfunction

  function automatic t_ring_req in_slot();
    t_ring_req s;
    s.valid     = RingReqInValid;
    s.requestor = RingReqInRequestor;
    s.opcode    = RingReqInOpcode;
    s.address   = RingReqInAddress;
    s.data      = RingReqInData;
    return s;
  endfunction

  task automatic step();
    t_ring_req e;
    @(posedge QClk);
    #1;
    check("sb_depth", 128'(sb.size()), 128'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("slot", 128'(dut_slot), 128'(e));
    end
  endtask

  // Inputs are already applied; check the combinational grant, queue the expected slot, advance one edge.
  task automatic cyc(input string tag, input logic [3:0] exp_grant, input t_ring_req e);
    #1;
    check(tag, 128'(ThreadReqGrant), 128'(exp_grant));
    sb.push_back(e);
    step();
  endtask

  initial begin
    RstQnnnH = 1'b1;
    CoreID = 8'd2;
    ThreadReqValid = 4'hF;
    for (int t = 0; t < 4; t++) begin
      ThreadReqOpcode[t]  = (t % 2 == 1) ? WR_REQ : RD_REQ;
      ThreadReqAddress[t] = 32'h1000_0000 + 32'(t);
      ThreadReqData[t]    = 32'hD000_0000 + 32'(t);
    end
    RingReqInValid = 1'b0; RingReqInTaken = 1'b0; RingReqInRequestor = '0;
    RingReqInOpcode = NOP; RingReqInAddress = '0; RingReqInData = '0;
    RingRspInValid = 1'b0; RingRspInRequestor = '0; RingRspInOpcode = NOP;

    cyc("rst_grant", 4'h0, '0);
    check("rst_outst", 128'(ThreadOutstanding), 128'(0));
    check("rst_tmo", 128'(ThreadTimeout), 128'(0));
    check("rst_starve", 128'(StarveFlag), 128'(0));
    RstQnnnH = 1'b0;

    RingReqInValid = 1'b1; RingReqInTaken = 1'b0; RingReqInRequestor = 10'h0C1;
    RingReqInOpcode = WR_REQ; RingReqInAddress = 32'hCAFE_BABE; RingReqInData = 32'h1234_5678;
    cyc("pt_grant", 4'h0, in_slot());
    check("pt_outst", 128'(ThreadOutstanding), 128'(0));

    RingReqInTaken = 1'b1;
    cyc("rr_t0", 4'b0001, thr_slot(0));
    RingReqInValid = 1'b0; RingReqInTaken = 1'b0;
    cyc("rr_t1", 4'b0010, thr_slot(1));
    cyc("rr_t2", 4'b0100, thr_slot(2));
    cyc("rr_t3", 4'b1000, thr_slot(3));
    check("rr_all_outst", 128'(ThreadOutstanding), 128'(4'hF));
    cyc("rr_none", 4'h0, '0);

    RingRspInValid = 1'b1; RingRspInRequestor = 10'h00E; RingRspInOpcode = RD_RSP;
    cyc("rsp_other_core", 4'h0, '0);
    check("rsp_other_outst", 128'(ThreadOutstanding), 128'(4'hF));
    RingRspInRequestor = 10'h00A;
    cyc("rsp_t2", 4'h0, '0);
    check("rsp_t2_outst", 128'(ThreadOutstanding), 128'(4'b1011));
    RingRspInValid = 1'b0;
    cyc("regrant_t2", 4'b0100, thr_slot(2));
    check("tmo_early", 128'(ThreadTimeout), 128'(0));

    // T0 went outstanding eight edges ago; its timeout fires at this edge.
    cyc("tmo_wait", 4'h0, '0);
    check("tmo_pulse", 128'(ThreadTimeout), 128'(4'b0001));
    check("tmo_outst", 128'(ThreadOutstanding), 128'(4'b1110));

    // T1 reaches its timeout in the same cycle its response arrives: clear without pulse.
    RingRspInValid = 1'b1; RingRspInRequestor = 10'h009; RingRspInOpcode = WR_RSP;
    cyc("tmo_regrant_t0", 4'b0001, thr_slot(0));
    check("race_no_pulse", 128'(ThreadTimeout), 128'(0));
    check("race_outst", 128'(ThreadOutstanding), 128'(4'b1101));
    RingRspInValid = 1'b0;
    cyc("grant_t1", 4'b0010, thr_slot(1));

    RstQnnnH = 1'b1;
    cyc("midrst_grant", 4'h0, '0);
    check("midrst_outst", 128'(ThreadOutstanding), 128'(0));
    check("midrst_tmo", 128'(ThreadTimeout), 128'(0));
    RstQnnnH = 1'b0;
    cyc("post_rst_t0", 4'b0001, thr_slot(0));
    ThreadReqValid = 4'b0000;
    cyc("no_req", 4'h0, '0);
    ThreadReqValid = 4'b1010;
    cyc("sparse_t1", 4'b0010, thr_slot(1));

    RstQnnnH = 1'b1;
    cyc("rst2_grant", 4'h0, '0);
    RstQnnnH = 1'b0;
    ThreadReqValid = 4'b0010;
    RingReqInValid = 1'b1; RingReqInTaken = 1'b0;
    for (int i = 0; i < 16; i++) begin
      RingReqInRequestor = 10'(10'h100 + i);
      RingReqInAddress   = 32'hA000_0000 + 32'(i);
      RingReqInData      = 32'(i * 3);
      cyc("starve_pt", 4'h0, in_slot());
      check("starve_flag", 128'(StarveFlag), 128'(STARVE_EN && (i + 1) >= 15));
    end
    RingReqInValid = 1'b0;
    cyc("starve_grant", 4'b0010, thr_slot(1));
    check("starve_clear", 128'(StarveFlag), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lotr_ring_inj_arb.md
Name: lotr_ring_inj_arb

Overview:
- Ring-stop injection arbiter for one tile on the LOTR request ring.
- Shares the tile's single outgoing ring request slot between upstream pass-through traffic and the tile's NUM_THREADS local thread requesters, using round-robin.
- Tracks one outstanding request per thread, cleared by the matching response seen on the response ring or by a timeout.
- Sits between the ring-in registers and the ring-out registers of the tile's ring controller.

Parameters:
- NUM_THREADS, 4, number of local requesters; fixed at 4 by the 2-bit thread field of the requestor ID.
- RSP_TIMEOUT, 1023, cycles an outstanding request may wait for its response before it is force-cleared.
- STARVE_LIMIT, 15, blocked-cycle threshold used only by the optional feature.

Ports:
- QClk  in  1  clock.
- RstQnnnH  in  1  reset, synchronous, active-high.
- CoreID  in  8  tile ID; upper field of the requestor ID.
- ThreadReqValid  in  NUM_THREADS  per-thread request pending.
- ThreadReqOpcode  in  t_opcode x NUM_THREADS  per-thread opcode.
- ThreadReqAddress  in  32 x NUM_THREADS  per-thread address.
- ThreadReqData  in  32 x NUM_THREADS  per-thread write data.
- ThreadReqGrant  out  NUM_THREADS  one-hot, combinational; payload is accepted this cycle.
- ThreadOutstanding  out  NUM_THREADS  request in flight per thread.
- ThreadTimeout  out  NUM_THREADS  1-cycle pulse when a timeout clears an outstanding request.
- RingReqInValid / RingReqInRequestor / RingReqInOpcode / RingReqInAddress / RingReqInData  in  1/10/t_opcode/32/32  upstream request slot.
- RingReqInTaken  in  1  the local target consumed the upstream slot this cycle.
- RingRspInValid / RingRspInRequestor / RingRspInOpcode  in  1/10/t_opcode  response ring; observed only, never consumed here.
- RingReqOutValid / RingReqOutRequestor / RingReqOutOpcode / RingReqOutAddress / RingReqOutData  out  1/10/t_opcode/32/32  registered downstream slot.
- StarveFlag  out  1  see Optional Feature.

Behaviour:
- Reset (any cycle, including mid-transaction):
  - RingReqOut* = 0; ThreadOutstanding = 0; ThreadTimeout = 0; StarveFlag = 0.
  - Round-robin pointer RrPtr = 0; all counters = 0.
  - ThreadReqGrant is forced to 0 while RstQnnnH = 1.
- Pass-through = RingReqInValid && !RingReqInTaken.
  - Pass-through has absolute priority.
  - The upstream slot is copied unchanged into RingReqOut* at the next edge (1-cycle latency); no grants are issued that cycle.
- Slot free = !pass-through.
- Thread t is eligible when ThreadReqValid[t] && !ThreadOutstanding[t].
- When the slot is free and any thread is eligible:
  - Winner = first eligible thread searching RrPtr, RrPtr+1, ... modulo NUM_THREADS.
  - ThreadReqGrant[winner] = 1 in the same cycle.
  - Next edge: RingReqOutValid = 1, Requestor = {CoreID, winner[1:0]}, Opcode/Address/Data taken from the winner's inputs.
  - Next edge: ThreadOutstanding[winner] = 1; RrPtr = (winner+1) mod NUM_THREADS.
- When the slot is free and no thread is eligible: RingReqOutValid = 0 and all out payload fields = 0. RrPtr holds.
- Response match: RingRspInValid && RingRspInRequestor[9:2] == CoreID && opcode is RD_RSP or WR_RSP. On a match, ThreadOutstanding[RingRspInRequestor[1:0]] is cleared at the next edge.
  - A match for a thread that is not outstanding is ignored.
  - If a match and a grant for the same thread occur in the same cycle, the set wins.
- Timeout: per-thread counter, cleared when the thread's outstanding bit is set, incremented each cycle the bit stays 1.
  - When the counter reaches RSP_TIMEOUT: ThreadOutstanding[t] clears, ThreadTimeout[t] pulses 1 cycle, counter returns to 0.
  - A response match in the same cycle clears normally with no pulse.
  - Counter width = $clog2(RSP_TIMEOUT+1); counters never wrap.
- ThreadReqValid deasserting without a grant is legal; no state is kept for that thread.

Optional Feature:
- Macro: LOTR_INJ_STARVE_CNT_EN.
- Defined:
  - A saturating counter increments each cycle any thread is eligible and the slot is taken by pass-through; it resets to 0 on any grant.
  - StarveFlag = 1 while the counter >= STARVE_LIMIT.
  - Arbitration is unaffected.
- Undefined: no counter; StarveFlag tied to 0.

Decomposition:
- lotr_pkg (existing) holds:
  - t_opcode;
  - constants for the requestor ID field split: CORE_ID_MSB = 9, CORE_ID_LSB = 2, THREAD_ID_W = 2;
  - a packed struct t_ring_req {valid, requestor, opcode, address, data}, used for the In/Out slot registers.
- One sub-module, lotr_rr_picker: a combinational round-robin one-hot picker taking eligible[] and RrPtr and returning the winner index plus an any-valid bit.

Test Plan:
- Reset mid-grant: RstQnnnH = 1 in the cycle after a grant -> next cycle RingReqOutValid = 0, ThreadOutstanding = 0, RrPtr = 0.
- Pass-through priority: RingReqInValid = 1, Taken = 0, Requestor = 0x0C1, with all 4 threads valid -> no grants; next cycle RingReqOut* equals the input slot exactly.
- Round-robin: CoreID = 2, all threads valid, ring idle -> grants in order T0, T1, T2, T3; Requestor = 0x008, 0x009, 0x00A, 0x00B; then no grants (all outstanding).
- Response clear: RingRspInValid with Requestor = 0x00A and RD_RSP -> ThreadOutstanding[2] drops next cycle and T2 is grantable again. Requestor = 0x00E (CoreID 3) -> no change.
- Timeout: RSP_TIMEOUT = 8, no response -> ThreadTimeout[0] pulses exactly 8 cycles after the outstanding bit sets, and the bit clears.
- Starvation (macro on, STARVE_LIMIT = 15): 15 consecutive pass-through cycles with T1 eligible -> StarveFlag = 1 in cycle 16; it clears in the cycle after T1 is granted.
